// File: rtl/uart_rx_sequencer_if.sv
// Host-side handshake bundle for the UART receive sequencer: one received word
// plus its error flags, delivered under valid/ready.
interface uart_rx_sequencer_if #(
   parameter int DATA_BITS = 8
);
   logic [DATA_BITS-1:0] rx_data;
   logic                 rx_valid;
   logic                 rx_ready;
   logic                 parity_error;
   logic                 frame_error;
   logic                 overrun;

   modport master (
      output rx_data, rx_valid, parity_error, frame_error, overrun,
      input  rx_ready
   );

   modport slave (
      input  rx_data, rx_valid, parity_error, frame_error, overrun,
      output rx_ready
   );
endinterface

// File: rtl/uart_rx_sequencer.sv
// UART receive sequencer: synchronises and oversamples rx_in, frames start/data/
// parity/stop bits, and hands each word with parity/framing/overrun flags to the host.
module uart_rx_sequencer #(
   parameter int OVS       = 16,
   parameter int DATA_BITS = 8,
   parameter int DIV_W     = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [DIV_W-1:0]     baud_div,
   input  logic                 rx_in,
   input  logic                 par_en,
   input  logic                 par_odd,
   uart_rx_sequencer_if.master  rx_bus,
   output logic                 busy,
   output logic                 sample_stb,
   output logic                 sample_bit
);
   localparam int OVS_W = (OVS > 2) ? $clog2(OVS) : 1;
   localparam int BIT_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
   localparam logic [OVS_W-1:0] OVS_LAST = OVS_W'(OVS - 1);
   localparam logic [OVS_W-1:0] OVS_MID  = OVS_W'(OVS / 2 - 1);
   localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_BITS - 1);

   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BRK} state_t;

   state_t               state, state_nxt;
   logic                 rx_sync_p0, rx_sync_p1, rx_s;
   logic [DIV_W-1:0]     div_cnt;
   logic                 tick;
   logic [OVS_W-1:0]     ovs_cnt;
   logic [BIT_W-1:0]     bit_cnt;
   logic [DATA_BITS-1:0] shift_q;
   logic                 perr;
   logic                 mid_start, bit_done;
   logic                 data_smp, par_smp, commit;
   logic [DATA_BITS-1:0] data_q;
   logic                 valid_q, perr_q, ferr_q, ovr_q;
   logic                 accept;

   function automatic logic exp_parity(input logic [DATA_BITS-1:0] d, input logic odd);
      return (^d) ^ odd;
   endfunction

   assign rx_s      = rx_sync_p1;
   assign tick      = (div_cnt == baud_div);
   assign mid_start = tick && (ovs_cnt == OVS_MID);
   assign bit_done  = tick && (ovs_cnt == OVS_LAST);
   assign accept    = valid_q && rx_bus.rx_ready;

   assign rx_bus.rx_data      = data_q;
   assign rx_bus.rx_valid     = valid_q;
   assign rx_bus.parity_error = perr_q;
   assign rx_bus.frame_error  = ferr_q;
   assign rx_bus.overrun      = ovr_q;

   always_ff @(posedge clk) begin
      if (!rst) state <= IDLE;
      else      state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (!rx_s) state_nxt = START;
         START:   if (mid_start) state_nxt = rx_s ? IDLE : DATA;
         DATA:    if (bit_done && (bit_cnt == BIT_LAST)) state_nxt = par_en ? PARITY : STOP;
         PARITY:  if (bit_done) state_nxt = STOP;
         STOP:    if (bit_done) state_nxt = rx_s ? IDLE : BRK;
         BRK:     if (rx_s) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      busy     = (state != IDLE);
      data_smp = (state == DATA)   && bit_done;
      par_smp  = (state == PARITY) && bit_done;
      commit   = (state == STOP)   && bit_done;
   end

   // p0/p1: two-flop synchroniser; bit timing runs off the synchronised rx_s
   always_ff @(posedge clk) begin
      if (!rst) begin
         rx_sync_p0 <= 1'b1;
         rx_sync_p1 <= 1'b1;
         div_cnt    <= '0;
         ovs_cnt    <= '0;
         bit_cnt    <= '0;
         shift_q    <= '0;
         perr       <= 1'b0;
         sample_stb <= 1'b0;
         sample_bit <= 1'b0;
      end else begin
         rx_sync_p0 <= rx_in;
         rx_sync_p1 <= rx_sync_p0;
         div_cnt    <= tick ? '0 : div_cnt + 1'b1;
         if ((state_nxt != state) || bit_done) ovs_cnt <= '0;
         else if (tick)                        ovs_cnt <= ovs_cnt + 1'b1;
         if (state != DATA)  bit_cnt <= '0;
         else if (data_smp)  bit_cnt <= bit_cnt + 1'b1;
         // Shifting right from the MSB lands the first-received bit in bit 0
         if (data_smp) shift_q <= {rx_s, shift_q[DATA_BITS-1:1]};
         if ((state_nxt == START) && (state != START)) perr <= 1'b0;
         else if (par_smp) perr <= (rx_s != exp_parity(shift_q, par_odd));
         sample_stb <= data_smp;
         if (data_smp) sample_bit <= rx_s;
      end
   end

   // Output word register: commit wins over a simultaneous accept
   always_ff @(posedge clk) begin
      if (!rst) begin
         data_q  <= '0;
         valid_q <= 1'b0;
         perr_q  <= 1'b0;
         ferr_q  <= 1'b0;
         ovr_q   <= 1'b0;
      end else if (commit) begin
         data_q  <= shift_q;
         valid_q <= 1'b1;
         perr_q  <= perr;
         ferr_q  <= ~rx_s;
         ovr_q   <= valid_q && !rx_bus.rx_ready;
      end else if (accept) begin
         valid_q <= 1'b0;
         perr_q  <= 1'b0;
         ferr_q  <= 1'b0;
         ovr_q   <= 1'b0;
      end
   end
endmodule

// File: tb/tb_uart_rx_sequencer.sv
// Bench for uart_rx_sequencer: random and directed serial frames, expected words
// queued at send time and matched by an independent handshake monitor.
module tb_uart_rx_sequencer;
   localparam int OVS = 16;

   logic        clk;
   logic        rst;
   logic [15:0] baud_div;
   logic        rx_in;
   logic        par_en;
   logic        par_odd;
   logic        busy;
   logic        sample_stb;
   logic        sample_bit;

   uart_rx_sequencer_if #(.DATA_BITS(8)) bus ();

   uart_rx_sequencer #(.OVS(OVS), .DATA_BITS(8), .DIV_W(16)) dut (
      .clk        (clk),
      .rst        (rst),
      .baud_div   (baud_div),
      .rx_in      (rx_in),
      .par_en     (par_en),
      .par_odd    (par_odd),
      .rx_bus     (bus),
      .busy       (busy),
      .sample_stb (sample_stb),
      .sample_bit (sample_bit)
   );

   typedef struct packed {
      logic [7:0] d;
      logic       pe;
      logic       fe;
      logic       ov;
   } exp_t;

   exp_t exp_q[$];
   logic stb_q[$];
   int   errors = 0;
   int   checks = 0;
   int   ready_mode = 0;   // 0 random, 1 held low, 2 held high

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic clks(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Consumer ready driver
   initial begin
      bus.rx_ready = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         case (ready_mode)
            0:       bus.rx_ready = 1'($urandom_range(0, 1));
            1:       bus.rx_ready = 1'b0;
            default: bus.rx_ready = 1'b1;
         endcase
      end
   end

   // Monitor: collects sample strobes and scores each accepted word
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (rst === 1'b1 && sample_stb === 1'b1) stb_q.push_back(sample_bit);
         if (rst === 1'b1 && bus.rx_valid === 1'b1 && bus.rx_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_word: got %0h expected none", bus.rx_data);
            end else begin
               e = exp_q.pop_front();
               check("rx_word{data,pe,fe,ov}",
                     {21'd0, bus.rx_data, bus.parity_error, bus.frame_error, bus.overrun},
                     {21'd0, e.d, e.pe, e.fe, e.ov});
            end
         end
      end
   end

   task automatic send_frame(input logic [7:0] d, input logic pen, input logic podd,
                             input logic pbit, input logic stop, input int low_extra,
                             input bit expect_out, input bit ovr);
      int         bp;
      exp_t       e;
      logic [7:0] got;
      bp = OVS * (int'(baud_div) + 1);
      par_en  = pen;
      par_odd = podd;
      stb_q.delete();
      if (expect_out) begin
         e.d  = d;
         e.pe = pen && (pbit != ((^d) ^ podd));
         e.fe = !stop;
         e.ov = ovr;
         exp_q.push_back(e);
      end
      rx_in = 1'b0;
      clks(bp);
      for (int i = 0; i < 8; i++) begin
         rx_in = d[i];
         clks(bp);
      end
      if (pen) begin
         rx_in = pbit;
         clks(bp);
      end
      rx_in = stop;
      clks(bp);
      if (!stop) begin
         clks(low_extra);
         check("brk_busy_while_low", 32'(busy), 32'd1);
      end
      rx_in = 1'b1;
      clks(2 * bp);
      check("idle_after_frame", 32'(busy), 32'd0);
      got = '0;
      for (int i = 0; i < stb_q.size() && i < 8; i++) got[i] = stb_q[i];
      check("stb_count", 32'(stb_q.size()), 32'd8);
      check("stb_bits", 32'(got), 32'(d));
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] d;
      rst = 1'b0;
      rx_in = 1'b1;
      baud_div = 16'd0;
      par_en = 1'b0;
      par_odd = 1'b0;
      clks(3);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_valid", 32'(bus.rx_valid), 32'd0);
      check("rst_data", 32'(bus.rx_data), 32'd0);
      check("rst_flags", {29'd0, bus.parity_error, bus.frame_error, bus.overrun}, 32'd0);
      check("rst_stb", {30'd0, sample_stb, sample_bit}, 32'd0);
      rst = 1'b1;
      clks(4);

      // Plain frame, then even parity wrong/right
      send_frame(8'hA5, 1'b0, 1'b0, 1'b0, 1'b1, 0, 1'b1, 1'b0);
      send_frame(8'h03, 1'b1, 1'b0, 1'b1, 1'b1, 0, 1'b1, 1'b0);
      send_frame(8'h03, 1'b1, 1'b0, 1'b0, 1'b1, 0, 1'b1, 1'b0);

      // False start: short low pulse
      stb_q.delete();
      rx_in = 1'b0;
      clks(4);
      check("false_start_busy", 32'(busy), 32'd1);
      rx_in = 1'b1;
      clks(9);
      check("false_start_idle", 32'(busy), 32'd0);
      check("false_start_valid", 32'(bus.rx_valid), 32'd0);
      clks(20);
      check("false_start_stb", 32'(stb_q.size()), 32'd0);

      // Break: stop bit low, line held low a further 40 ticks
      send_frame(8'h55, 1'b0, 1'b0, 1'b0, 1'b0, 40, 1'b1, 1'b0);
      send_frame(8'h12, 1'b0, 1'b0, 1'b0, 1'b1, 0, 1'b1, 1'b0);

      // Overrun: two words with no acceptance
      ready_mode = 1;
      clks(2);
      send_frame(8'h11, 1'b0, 1'b0, 1'b0, 1'b1, 0, 1'b0, 1'b0);
      send_frame(8'h22, 1'b0, 1'b0, 1'b0, 1'b1, 0, 1'b1, 1'b1);
      check("ovr_valid", 32'(bus.rx_valid), 32'd1);
      check("ovr_flag", 32'(bus.overrun), 32'd1);
      check("ovr_data", 32'(bus.rx_data), 32'h22);
      ready_mode = 2;
      for (int i = 0; i < 10 && bus.rx_valid !== 1'b0; i++) clks(1);
      check("ovr_accept_valid", 32'(bus.rx_valid), 32'd0);
      check("ovr_accept_flag", 32'(bus.overrun), 32'd0);
      check("ovr_data_held", 32'(bus.rx_data), 32'h22);
      ready_mode = 0;
      clks(4);

      // Reset in the middle of data bit 3
      stb_q.delete();
      d = 8'hF0;
      rx_in = 1'b0;
      clks(OVS);
      for (int i = 0; i < 3; i++) begin
         rx_in = d[i];
         clks(OVS);
      end
      rx_in = d[3];
      clks(OVS / 2);
      rst = 1'b0;
      rx_in = 1'b1;
      clks(1);
      check("abort_busy", 32'(busy), 32'd0);
      check("abort_outputs", {22'd0, bus.rx_data, bus.rx_valid, sample_stb}, 32'd0);
      rst = 1'b1;
      clks(OVS * 8);
      check("abort_no_valid", 32'(bus.rx_valid), 32'd0);

      // Random frames with random divider and parity settings
      for (int n = 0; n < 12; n++) begin
         baud_div = 16'($urandom_range(0, 2));
         send_frame(8'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)), 1'b1, 0, 1'b1, 1'b0);
      end

      for (int i = 0; i < 3000 && exp_q.size() != 0; i++) clks(1);
      check("queue_drained", 32'(exp_q.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
